// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline register with main + skid entry, valid/ready handshake,
// registered in_ready and flush that squashes held and incoming instructions.
module pipe_stage_reg #(
    parameter int                DATA_W      = 256,
    parameter int                CTRL_W      = 9,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t            state, nxt;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              accept, consume, load_in, load_skid, skid_to_main;
    always_comb begin
        accept  = in_valid & in_ready;
        consume = out_valid & out_ready;
        nxt     = state;
        if (flush)
            nxt = EMPTY;
        else
            case (state)
                EMPTY:   nxt = accept ? ONE : EMPTY;
                ONE:     nxt = (accept & !consume) ? FULL : (!accept & consume) ? EMPTY : ONE;
                FULL:    nxt = consume ? ONE : FULL;
                default: nxt = EMPTY;
            endcase
        load_in      = !flush & accept & (state == EMPTY | consume);
        load_skid    = !flush & accept & (state == ONE) & !consume;
        skid_to_main = !flush & (state == FULL) & consume;
    end
    // out_ctrl doubles as the main control store; it is forced to the bubble when the stage empties
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_ctrl  <= BUBBLE_CTRL;
            out_data  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state     <= nxt;
            in_ready  <= nxt != FULL;
            out_valid <= nxt != EMPTY;
            if (load_in) begin
                out_ctrl <= in_ctrl;
                out_data <= in_data;
            end else if (skid_to_main) begin
                out_ctrl <= skid_ctrl;
                out_data <= skid_data;
            end else if (nxt == EMPTY) begin
                out_ctrl <= BUBBLE_CTRL;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end
    assign occupancy = state;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed + random stimulus against a 2-deep FIFO scoreboard.
module tb_pipe_stage_reg;
    localparam int             DW  = 64;
    localparam int             CW  = 9;
    localparam logic [CW-1:0]  BUB = 9'h0A5;

    logic          clock = 1'b0, reset = 1'b0;
    logic          in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic          in_ready, out_valid;
    logic [CW-1:0] in_ctrl = '0, out_ctrl;
    logic [DW-1:0] in_data = '0, out_data;
    logic [1:0]    occupancy;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    typedef struct packed {logic [CW-1:0] c; logic [DW-1:0] d;} ent_t;
    ent_t          exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] want[$];
    int            tests = 0, fails = 0;
    bit            started = 0, acc, cons;

    task automatic chk(string n, logic [DW-1:0] a, logic [DW-1:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [CW-1:0] cf(logic [DW-1:0] d);
        return CW'(d * 7 + 3);
    endfunction

    task automatic chk_got(string n);
        chk({n, "_count"}, DW'(got_q.size()), DW'(want.size()));
        for (int i = 0; i < want.size() && i < got_q.size(); i++) chk(n, got_q[i], want[i]);
    endtask

    task automatic drive(bit v, logic [DW-1:0] d, bit r, bit f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = cf(d);
        out_ready = r;
        flush     = f;
        @(posedge clock);
        #1;
    endtask

    // reference model: ordered queue of held instructions, updated on each edge
    always @(posedge clock) begin
        started = 1;
        if (!reset) exp_q.delete();
        else begin
            acc  = in_valid && exp_q.size() < 2;
            cons = exp_q.size() > 0 && out_ready;
            if (flush) exp_q.delete();
            else begin
                if (cons) void'(exp_q.pop_front());
                if (acc) exp_q.push_back('{c: in_ctrl, d: in_data});
            end
        end
    end

    always @(negedge clock) if (started) begin
        chk("occupancy", DW'(occupancy), DW'(exp_q.size()));
        chk("in_ready", DW'(in_ready), DW'(exp_q.size() != 2));
        chk("out_valid", DW'(out_valid), DW'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q[0].d);
            chk("out_ctrl", DW'(out_ctrl), DW'(exp_q[0].c));
        end else chk("bubble_ctrl", DW'(out_ctrl), DW'(BUB));
        if (out_valid && out_ready) got_q.push_back(out_data);
    end

    initial begin
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("rst_occ", DW'(occupancy), 0);
        chk("rst_valid", DW'(out_valid), 0);
        chk("rst_ready", DW'(in_ready), 1);
        chk("rst_ctrl", DW'(out_ctrl), DW'(BUB));
        chk("rst_data", out_data, 0);
        reset = 1'b1;
        got_q.delete();
        for (int i = 1; i <= 8; i++) begin
            drive(1, DW'(i), 1, 0);
            chk("stream_occ", DW'(occupancy), 1);
            chk("stream_data", out_data, DW'(i));
        end
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        want.delete();
        for (int i = 1; i <= 8; i++) want.push_back(DW'(i));
        chk_got("stream_order");

        got_q.delete();
        drive(1, 'hA, 0, 0);
        chk("skid_a_occ", DW'(occupancy), 1);
        chk("skid_a_data", out_data, 'hA);
        drive(1, 'hB, 0, 0);
        chk("skid_b_occ", DW'(occupancy), 2);
        chk("skid_b_ready", DW'(in_ready), 0);
        drive(1, 'hC, 0, 0);
        chk("skid_c_held_occ", DW'(occupancy), 2);
        chk("skid_c_held_data", out_data, 'hA);
        drive(1, 'hC, 1, 0);
        chk("skid_rel_occ", DW'(occupancy), 1);
        chk("skid_rel_data", out_data, 'hB);
        drive(1, 'hC, 1, 0);
        chk("skid_c_data", out_data, 'hC);
        drive(0, 0, 1, 0);
        chk("skid_drain_occ", DW'(occupancy), 0);
        want.delete();
        want.push_back('hA);
        want.push_back('hB);
        want.push_back('hC);
        chk_got("skid_order");

        got_q.delete();
        drive(1, 'h11, 0, 0);
        drive(1, 'h22, 0, 0);
        chk("flush_full", DW'(occupancy), 2);
        drive(1, 'hD, 0, 1);
        chk("flush_valid", DW'(out_valid), 0);
        chk("flush_ctrl", DW'(out_ctrl), DW'(BUB));
        chk("flush_occ", DW'(occupancy), 0);
        chk("flush_ready", DW'(in_ready), 1);
        chk("flush_hold", out_data, 'h11);
        drive(0, 0, 1, 1);
        chk("flush2_occ", DW'(occupancy), 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        want.delete();
        chk_got("flush_no_d");

        drive(1, 'h33, 0, 0);
        drive(1, 'h44, 0, 0);
        chk("mid_full", DW'(occupancy), 2);
        reset = 1'b0;
        drive(1, 'h55, 1, 1);
        chk("mid_rst_occ", DW'(occupancy), 0);
        chk("mid_rst_valid", DW'(out_valid), 0);
        chk("mid_rst_ctrl", DW'(out_ctrl), DW'(BUB));
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_ready", DW'(in_ready), 1);
        reset = 1'b1;
        got_q.delete();
        drive(1, 'hE, 1, 0);
        chk("e_occ", DW'(occupancy), 1);
        chk("e_data", out_data, 'hE);
        drive(0, 0, 1, 0);
        chk("e_drain", DW'(occupancy), 0);
        want.delete();
        want.push_back('hE);
        chk_got("e_alone");

        for (int i = 0; i < 3000; i++)
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
